rock_sequencer: RTL and testbench

//  Closed-loop controller for the cradle rocking motor, clocked on the slow tick.

---
 rtl/rock_pkg.sv | 15 +
 rtl/rock_sequencer_if.sv | 11 +
 rtl/rock_tick_timer.sv | 25 ++
 rtl/rock_sequencer.sv | 165 ++++++++++++++++
 tb/tb_rock_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rock_pkg.sv
// Shared definitions for the cradle rocking controller and the motor driver.
package rock_pkg;

  localparam int LEVEL_W_DEF   = 3;
  localparam int MAX_LEVEL_DEF = 7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_EVAL   = 3'd3,
    ST_ALARM  = 3'd4
  } rock_state_e;

endpackage

// File: rtl/rock_sequencer_if.sv
// Level command channel from the rocking sequencer to the motor driver.
interface rock_sequencer_if #(
  parameter int LEVEL_W = rock_pkg::LEVEL_W_DEF
);
  logic               cmd_valid;
  logic [LEVEL_W-1:0] cmd_level;
  logic               cmd_ready;

  modport master (output cmd_valid, output cmd_level, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_level, output cmd_ready);
endinterface

// File: rtl/rock_tick_timer.sv
// Loadable saturating down-counter on the slow tick; done while the count is zero.
module rock_tick_timer #(
  parameter int W = 5
) (
  input  logic         slow,
  input  logic         resetSlower,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge slow or posedge resetSlower) begin
    if (resetSlower) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_o = (cnt_q == '0);
endmodule

// File: rtl/rock_sequencer.sv
// Closed-loop cradle rocking controller: steps motor intensity from heart-rate trends
// and raises an alarm when maximum intensity or a dead sensor leaves the baby uncalmed.
module rock_sequencer
  import rock_pkg::*;
#(
  parameter int LEVEL_W      = LEVEL_W_DEF,
  parameter int MAX_LEVEL    = MAX_LEVEL_DEF,
  parameter int START_LEVEL  = 3,
  parameter int SETTLE_TICKS = 16,
  parameter int CALM_LIMIT   = 4
) (
  input  logic       slow,
  input  logic       resetSlower,
  input  logic       start,
  input  logic       stop,
  input  logic [5:0] hart,
  input  logic       gelijkPuls,
  input  logic       gedaald,
  input  logic       error,
  input  logic       alarm_ack,
  rock_sequencer_if.master cmd_if,
  output logic       rocking,
  output logic       alarm
);
  localparam int TMR_W  = $clog2(SETTLE_TICKS + 1);
  localparam int CALM_W = $clog2(CALM_LIMIT + 1);
  localparam logic [LEVEL_W-1:0] MAX_L   = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] START_L = LEVEL_W'(START_LEVEL);
  localparam logic [CALM_W-1:0]  CALM_TOP = CALM_W'(CALM_LIMIT - 1);
  localparam logic [TMR_W-1:0]   SETTLE_LOAD = TMR_W'(SETTLE_TICKS - 1);

  rock_state_e        state_q;
  logic [LEVEL_W-1:0] level_q;
  logic [LEVEL_W-1:0] cmd_level_q;
  logic               cmd_valid_q;
  logic               abort_q;
  logic [CALM_W-1:0]  calm_q;
  logic               hart_zero_q;
  logic               rocking_q;
  logic               alarm_q;

  logic               hs;
  logic               sensor_fault;
  logic               settle_done;
  logic [LEVEL_W-1:0] level_dn;
  logic [LEVEL_W-1:0] level_up;

  assign hs           = cmd_valid_q & cmd_if.cmd_ready;
  assign sensor_fault = (state_q != ST_IDLE) && (hart == 6'd0) && hart_zero_q;
  assign level_dn     = (level_q == '0) ? '0 : level_q - LEVEL_W'(1);
  assign level_up     = level_q + LEVEL_W'(1);

  // Timer reloads whenever we are outside SETTLE, so every entry starts a full window.
  rock_tick_timer #(.W(TMR_W)) u_settle (
    .slow        (slow),
    .resetSlower (resetSlower),
    .load_i      (state_q != ST_SETTLE),
    .en_i        (state_q == ST_SETTLE),
    .load_val_i  (SETTLE_LOAD),
    .done_o      (settle_done)
  );

  always_ff @(posedge slow or posedge resetSlower) begin
    if (resetSlower) begin
      state_q     <= ST_IDLE;
      level_q     <= '0;
      cmd_level_q <= '0;
      cmd_valid_q <= 1'b0;
      abort_q     <= 1'b0;
      calm_q      <= '0;
      hart_zero_q <= 1'b0;
      rocking_q   <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      hart_zero_q <= (state_q != ST_IDLE) && (hart == 6'd0);
      case (state_q)
        ST_IDLE: begin
          if (!stop && (start || (gelijkPuls && gedaald))) begin
            cmd_level_q <= START_L;
            cmd_valid_q <= 1'b1;
            state_q     <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (hs) begin
            level_q   <= cmd_level_q;
            rocking_q <= (cmd_level_q != '0);
            calm_q    <= '0;
            abort_q   <= 1'b0;
            // A stop seen while a nonzero command was in flight becomes a follow-up zero command.
            if ((stop || abort_q) && cmd_level_q != '0) begin
              cmd_level_q <= '0;
            end else begin
              cmd_valid_q <= 1'b0;
              if (cmd_level_q == '0) begin
                state_q <= ST_IDLE;
              end else if (sensor_fault) begin
                alarm_q <= 1'b1;
                state_q <= ST_ALARM;
              end else begin
                state_q <= ST_SETTLE;
              end
            end
          end else if (stop) begin
            abort_q <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (stop) begin
            cmd_level_q <= '0;
            cmd_valid_q <= 1'b1;
            state_q     <= ST_CMD;
          end else if (sensor_fault) begin
            alarm_q <= 1'b1;
            state_q <= ST_ALARM;
          end else if (settle_done) begin
            state_q <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (stop) begin
            cmd_level_q <= '0;
            cmd_valid_q <= 1'b1;
            state_q     <= ST_CMD;
          end else if (sensor_fault) begin
            alarm_q <= 1'b1;
            state_q <= ST_ALARM;
          end else if (gelijkPuls) begin
            // gedaald outranks error: soothing harder is the safer mistake.
            if (gedaald) begin
              if (level_q < MAX_L) begin
                cmd_level_q <= level_up;
                cmd_valid_q <= 1'b1;
                calm_q      <= '0;
                state_q     <= ST_CMD;
              end else begin
                alarm_q <= 1'b1;
                state_q <= ST_ALARM;
              end
            end else if (error || calm_q >= CALM_TOP) begin
              cmd_level_q <= level_dn;
              cmd_valid_q <= 1'b1;
              calm_q      <= '0;
              state_q     <= ST_CMD;
            end else begin
              calm_q <= calm_q + CALM_W'(1);
            end
          end
        end
        ST_ALARM: begin
          if (alarm_ack) begin
            alarm_q <= 1'b0;
            state_q <= ST_SETTLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_if.cmd_valid = cmd_valid_q;
  assign cmd_if.cmd_level = cmd_level_q;
  assign rocking          = rocking_q;
  assign alarm            = alarm_q;
endmodule

// File: tb/tb_rock_sequencer.sv
// Directed bench for rock_sequencer with a handshake scoreboard of expected command levels.
module tb_rock_sequencer;
  logic       slow = 1'b0;
  logic       resetSlower;
  logic       start, stop, gelijkPuls, gedaald, error, alarm_ack;
  logic [5:0] hart;
  logic       rocking, alarm;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;
  int unsigned exp_q[$];

  rock_sequencer_if #(.LEVEL_W(3)) cmd_if ();

  rock_sequencer #(
    .LEVEL_W(3), .MAX_LEVEL(7), .START_LEVEL(3), .SETTLE_TICKS(16), .CALM_LIMIT(4)
  ) dut (
    .slow        (slow),
    .resetSlower (resetSlower),
    .start       (start),
    .stop        (stop),
    .hart        (hart),
    .gelijkPuls  (gelijkPuls),
    .gedaald     (gedaald),
    .error       (error),
    .alarm_ack   (alarm_ack),
    .cmd_if      (cmd_if),
    .rocking     (rocking),
    .alarm       (alarm)
  );

  always #5 slow = ~slow;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge slow);
    #1;
  endtask

  task automatic settle();
    repeat (16) tick();
  endtask

  // From EVAL with cmd_ready high: one trend pulse, command check, handshake.
  task automatic issue(input logic gd, input logic er, input int lvl);
    exp_q.push_back(lvl);
    gelijkPuls = 1'b1; gedaald = gd; error = er;
    tick();
    gelijkPuls = 1'b0; gedaald = 1'b0; error = 1'b0;
    chk("cmd_valid_up", cmd_if.cmd_valid, 1);
    chk("cmd_level", cmd_if.cmd_level, lvl);
    tick();
    chk("rocking_after_hs", rocking, (lvl != 0));
    chk("valid_drop", cmd_if.cmd_valid, 0);
  endtask

  // Scoreboard: a handshake completes at the next posedge whenever valid&ready at negedge.
  always @(negedge slow) begin
    if (resetSlower === 1'b0 && cmd_if.cmd_valid === 1'b1 && cmd_if.cmd_ready === 1'b1) begin
      chk("sb_pending", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("hs_level", cmd_if.cmd_level, exp_q.pop_front());
    end
  end

  initial begin
    int bad;
    resetSlower = 1'b1; start = 1'b0; stop = 1'b0; gelijkPuls = 1'b0; gedaald = 1'b0;
    error = 1'b0; alarm_ack = 1'b0; hart = 6'd20; cmd_if.cmd_ready = 1'b1;
    repeat (2) tick();
    chk("rst_valid", cmd_if.cmd_valid, 0);
    chk("rst_level", cmd_if.cmd_level, 0);
    chk("rst_rocking", rocking, 0);
    chk("rst_alarm", alarm, 0);
    resetSlower = 1'b0;
    tick();

    // Start: command for level 3 one tick later, accepted immediately.
    start = 1'b1; exp_q.push_back(3);
    tick();
    start = 1'b0;
    chk("start_valid", cmd_if.cmd_valid, 1);
    chk("start_level", cmd_if.cmd_level, 3);
    tick();
    chk("start_rocking", rocking, 1);

    // Trend pulses during the settle window are ignored.
    gelijkPuls = 1'b1; gedaald = 1'b1; bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (cmd_if.cmd_valid !== 1'b0) bad++;
    end
    chk("settle_ignored", bad, 0);

    // First EVAL pulse steps to 4; driver stalls for 5 ticks.
    cmd_if.cmd_ready = 1'b0; exp_q.push_back(4);
    tick();
    gelijkPuls = 1'b0; gedaald = 1'b0;
    chk("up4_valid", cmd_if.cmd_valid, 1);
    chk("up4_level", cmd_if.cmd_level, 4);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_level !== 3'd4) bad++;
    end
    chk("stall_hold", bad, 0);
    cmd_if.cmd_ready = 1'b1;
    tick();
    chk("up4_done_valid", cmd_if.cmd_valid, 0);

    settle(); issue(1'b1, 1'b0, 5);
    settle(); issue(1'b1, 1'b1, 6);   // both trends high: step up
    settle(); issue(1'b1, 1'b0, 7);

    // At max level a stress pulse alarms instead of commanding.
    settle();
    gelijkPuls = 1'b1; gedaald = 1'b1;
    tick();
    gelijkPuls = 1'b0; gedaald = 1'b0;
    chk("max_alarm", alarm, 1);
    chk("max_no_cmd", cmd_if.cmd_valid, 0);
    repeat (3) tick();
    chk("alarm_held", alarm, 1);
    alarm_ack = 1'b1;
    tick();
    alarm_ack = 1'b0;
    chk("ack_alarm", alarm, 0);
    chk("ack_no_cmd", cmd_if.cmd_valid, 0);
    chk("ack_rocking", rocking, 1);

    settle(); issue(1'b0, 1'b1, 6);
    settle(); issue(1'b0, 1'b1, 5);
    settle(); issue(1'b0, 1'b1, 4);
    settle(); issue(1'b0, 1'b1, 3);
    settle(); issue(1'b0, 1'b1, 2);

    // Four neutral stable pulses step down once.
    settle();
    gelijkPuls = 1'b1; bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cmd_if.cmd_valid !== 1'b0) bad++;
    end
    chk("calm_wait", bad, 0);
    exp_q.push_back(1);
    tick();
    gelijkPuls = 1'b0;
    chk("calm_valid", cmd_if.cmd_valid, 1);
    chk("calm_level", cmd_if.cmd_level, 1);
    tick();
    chk("calm_rocking", rocking, 1);
    settle(); issue(1'b0, 1'b1, 0);
    tick();
    chk("idle_quiet", cmd_if.cmd_valid, 0);

    // Sensor fault in EVAL.
    start = 1'b1; exp_q.push_back(3);
    tick();
    start = 1'b0;
    chk("restart_valid", cmd_if.cmd_valid, 1);
    tick();
    chk("restart_rocking", rocking, 1);
    settle();
    hart = 6'd0;
    tick();
    chk("fault_1tick", alarm, 0);
    tick();
    chk("fault_alarm", alarm, 1);
    hart = 6'd20;
    tick();
    chk("fault_latched", alarm, 1);
    alarm_ack = 1'b1;
    tick();
    alarm_ack = 1'b0;
    chk("fault_ack", alarm, 0);

    // Stop during SETTLE.
    repeat (2) tick();
    stop = 1'b1; exp_q.push_back(0);
    tick();
    stop = 1'b0;
    chk("stop_valid", cmd_if.cmd_valid, 1);
    chk("stop_level", cmd_if.cmd_level, 0);
    tick();
    chk("stop_rocking", rocking, 0);
    chk("stop_valid_drop", cmd_if.cmd_valid, 0);

    // Reset while a command is pending clears outputs without waiting for a clock.
    cmd_if.cmd_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("pre_rst_valid", cmd_if.cmd_valid, 1);
    #2 resetSlower = 1'b1;
    #1;
    chk("arst_valid", cmd_if.cmd_valid, 0);
    chk("arst_level", cmd_if.cmd_level, 0);
    chk("arst_rocking", rocking, 0);
    chk("arst_alarm", alarm, 0);
    tick();
    resetSlower = 1'b0; cmd_if.cmd_ready = 1'b1; start = 1'b1; exp_q.push_back(3);
    tick();
    start = 1'b0;
    chk("rerun_valid", cmd_if.cmd_valid, 1);
    chk("rerun_level", cmd_if.cmd_level, 3);
    tick();
    chk("rerun_rocking", rocking, 1);

    // Stop while a step-up is stalled: the 4 completes first, then a 0 follows.
    settle();
    cmd_if.cmd_ready = 1'b0; exp_q.push_back(4);
    gelijkPuls = 1'b1; gedaald = 1'b1;
    tick();
    gelijkPuls = 1'b0; gedaald = 1'b0;
    chk("abort_pre_level", cmd_if.cmd_level, 4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("abort_hold_level", cmd_if.cmd_level, 4);
    chk("abort_hold_valid", cmd_if.cmd_valid, 1);
    cmd_if.cmd_ready = 1'b1; exp_q.push_back(0);
    tick();
    chk("abort_next_valid", cmd_if.cmd_valid, 1);
    chk("abort_next_level", cmd_if.cmd_level, 0);
    chk("abort_mid_rocking", rocking, 1);
    tick();
    chk("abort_rocking", rocking, 0);
    chk("abort_valid_drop", cmd_if.cmd_valid, 0);

    tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
